// File: rtl/factorial_accel_pkg.sv
// rtl/factorial_accel_pkg.sv - shared FSM state type and register offsets for factorial_accel
//
// Contents:
//   state_t          - datapath FSM states (IDLE, CALC)
//   status_off(rb)   - offset of the status register for a result of rb bytes
//   start_off(rb)    - offset of the start strobe register
//   int_en_off(rb)   - offset of the interrupt-enable register
//   done_off(rb)     - offset of the done / done-clear register
package factorial_accel_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    // Result bytes occupy offsets 0..rb-1; control registers follow directly.
    function automatic int status_off(input int rb);
        return rb;
    endfunction

    function automatic int start_off(input int rb);
        return rb + 1;
    endfunction

    function automatic int int_en_off(input int rb);
        return rb + 2;
    endfunction

    function automatic int done_off(input int rb);
        return rb + 3;
    endfunction

endpackage

// File: rtl/factorial_core.sv
// rtl/factorial_core.sv - iterative factorial datapath: accumulator, counter, multiplier, FSM
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset
//   start     in   start request; only accepted in IDLE
//   done_clr  in   clear the done flag (a completion on the same edge wins)
//   n         in   DATA_W operand latched on an accepted start
//   busy      out  high while computing (state == CALC)
//   overflow  out  sticky: some partial product did not fit in RES_W bits
//   done      out  set when a computation completes
//   acc       out  RES_W result, n! mod 2^RES_W once done
module factorial_core
    import factorial_accel_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int RES_BYTES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        done_clr,
    input  logic [DATA_W-1:0]           n,
    output logic                        busy,
    output logic                        overflow,
    output logic                        done,
    output logic [DATA_W*RES_BYTES-1:0] acc
);

    localparam int RES_W = DATA_W * RES_BYTES;

    state_t              state;
    logic [DATA_W-1:0]   cnt;
    logic [RES_W+DATA_W-1:0] prod;

    // Full-width single-cycle product; the bits above RES_W flag overflow.
    assign prod = {{DATA_W{1'b0}}, acc} * {{RES_W{1'b0}}, cnt};
    assign busy = (state == CALC);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc      <= RES_W'(1);
                        cnt      <= n;
                        overflow <= 1'b0;
                        done     <= 1'b0;
                        state    <= CALC;
                    end else if (done_clr) begin
                        done <= 1'b0;
                    end
                end
                CALC: begin
                    if (done_clr) begin
                        done <= 1'b0;
                    end
                    if (cnt > DATA_W'(1)) begin
                        acc      <= prod[RES_W-1:0];
                        cnt      <= cnt - DATA_W'(1);
                        overflow <= overflow | (|prod[RES_W +: DATA_W]);
                    end else begin
                        // Completion overrides a coincident clear.
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/factorial_accel.sv
// rtl/factorial_accel.sv - memory-mapped factorial accelerator: register file and bus decode
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   asynchronous active-low reset
//   cs            in   chip select
//   readmem       in   read strobe (qualified by cs)
//   writemem      in   write strobe (qualified by cs, wins over readmem)
//   address       in   register offset
//   dataIn        in   write data
//   dataOut       out  registered read data
//   memDataReady  out  read data valid, one cycle after each read edge
//   interrupt     out  done & int_en
//
// Map: 0..RES_BYTES-1 result bytes LSB first (offset 0 write = operand n),
//      RES_BYTES status {overflow, busy}, +1 start, +2 int_en, +3 done / clear.
module factorial_accel
    import factorial_accel_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int RES_BYTES = 4,
    parameter int ADDR_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              readmem,
    input  logic              writemem,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] dataIn,
    output logic [DATA_W-1:0] dataOut,
    output logic              memDataReady,
    output logic              interrupt
);

    localparam int RES_W = DATA_W * RES_BYTES;
    localparam logic [ADDR_W-1:0] A_OPERAND = '0;
    localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(status_off(RES_BYTES));
    localparam logic [ADDR_W-1:0] A_START   = ADDR_W'(start_off(RES_BYTES));
    localparam logic [ADDR_W-1:0] A_INT_EN  = ADDR_W'(int_en_off(RES_BYTES));
    localparam logic [ADDR_W-1:0] A_DONE    = ADDR_W'(done_off(RES_BYTES));

    logic              wr;
    logic              rd;
    logic [DATA_W-1:0] n_reg;
    logic              int_en;
    logic              busy;
    logic              overflow;
    logic              done;
    logic [RES_W-1:0]  acc;
    logic [DATA_W-1:0] rdata;

    assign wr = cs & writemem;
    assign rd = cs & readmem & ~writemem;

    factorial_core #(
        .DATA_W    (DATA_W),
        .RES_BYTES (RES_BYTES)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .start    (wr && (address == A_START)),
        .done_clr (wr && (address == A_DONE)),
        .n        (n_reg),
        .busy     (busy),
        .overflow (overflow),
        .done     (done),
        .acc      (acc)
    );

    always_comb begin
        rdata = '0;
        for (int i = 0; i < RES_BYTES; i++) begin
            if (address == ADDR_W'(i)) begin
                rdata = acc[i*DATA_W +: DATA_W];
            end
        end
        if (address == A_STATUS) begin
            rdata = {{(DATA_W-2){1'b0}}, overflow, busy};
        end else if (address == A_INT_EN) begin
            rdata = {{(DATA_W-1){1'b0}}, int_en};
        end else if (address == A_DONE) begin
            rdata = {{(DATA_W-1){1'b0}}, done};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_reg        <= '0;
            int_en       <= 1'b0;
            dataOut      <= '0;
            memDataReady <= 1'b0;
        end else begin
            // Operand is frozen while a computation is running.
            if (wr && (address == A_OPERAND) && !busy) begin
                n_reg <= dataIn;
            end
            if (wr && (address == A_INT_EN)) begin
                int_en <= dataIn[0];
            end
            memDataReady <= rd;
            if (rd) begin
                dataOut <= rdata;
            end
        end
    end

    assign interrupt = done & int_en;

endmodule

// File: tb/tb_factorial_accel.sv
// tb/tb_factorial_accel.sv - scoreboard testbench for factorial_accel
module tb_factorial_accel;

    localparam int DATA_W    = 8;
    localparam int RES_BYTES = 4;
    localparam int ADDR_W    = 4;

    localparam logic [ADDR_W-1:0] A_STATUS = 4'd4;
    localparam logic [ADDR_W-1:0] A_START  = 4'd5;
    localparam logic [ADDR_W-1:0] A_INTEN  = 4'd6;
    localparam logic [ADDR_W-1:0] A_DONE   = 4'd7;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cs = 1'b0;
    logic              readmem = 1'b0;
    logic              writemem = 1'b0;
    logic [ADDR_W-1:0] address = '0;
    logic [DATA_W-1:0] dataIn = '0;
    logic [DATA_W-1:0] dataOut;
    logic              memDataReady;
    logic              interrupt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [7:0] val;
    } exp_t;
    exp_t sbq[$];

    factorial_accel #(
        .DATA_W    (DATA_W),
        .RES_BYTES (RES_BYTES),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cs           (cs),
        .readmem      (readmem),
        .writemem     (writemem),
        .address      (address),
        .dataIn       (dataIn),
        .dataOut      (dataOut),
        .memDataReady (memDataReady),
        .interrupt    (interrupt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: n! as a mathematical value, reported mod 2^32 plus whether it reached 2^32.
    function automatic void model(input int n, output logic [31:0] res, output bit ovf);
        longint unsigned p;
        p   = 1;
        ovf = 0;
        for (int i = 2; i <= n; i++) begin
            p = p * longint'(i);
            if (p >= 64'h1_0000_0000) begin
                ovf = 1;
                p   = p % 64'h1_0000_0000;
            end
        end
        res = p[31:0];
    endfunction

    // Monitor: every read response is compared against the oldest expectation.
    always @(negedge clk) begin
        if (memDataReady) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: got 0x%0h expected no response", dataOut);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk(e.name, {24'h0, dataOut}, {24'h0, e.val});
            end
        end
    end

    // Bus tasks start at a negedge and return at the negedge after their edge.
    task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        cs = 1'b1; writemem = 1'b1; readmem = 1'b0; address = a; dataIn = d;
        @(posedge clk);
        @(negedge clk);
        cs = 1'b0; writemem = 1'b0;
    endtask

    task automatic bus_read(input logic [ADDR_W-1:0] a, input logic [7:0] exp, input string name);
        exp_t e;
        e.name = name;
        e.val  = exp;
        sbq.push_back(e);
        cs = 1'b1; readmem = 1'b1; writemem = 1'b0; address = a;
        @(posedge clk);
        @(negedge clk);
        cs = 1'b0; readmem = 1'b0;
    endtask

    task automatic read_result(input logic [31:0] r, input bit ovf, input string tag);
        for (int b = 0; b < 4; b++) begin
            bus_read(ADDR_W'(b), r[b*8 +: 8], $sformatf("%s_byte%0d", tag, b));
        end
        bus_read(A_STATUS, {6'b0, ovf, 1'b0}, {tag, "_status"});
    endtask

    task automatic run_fact(input int n, input bit ie);
        logic [31:0] r;
        bit          ovf;
        int          m;
        string       tag;
        tag = $sformatf("n%0d", n);
        model(n, r, ovf);
        m = (n < 1) ? 1 : n;
        bus_write('0, 8'(n));
        bus_write(A_INTEN, {7'b0, ie});
        bus_write(A_START, 8'hA5);
        for (int i = 1; i <= m; i++) begin
            @(negedge clk);
            if (i == m - 1) chk({tag, "_irq_early"}, {31'b0, interrupt}, 32'd0);
            if (i == m)     chk({tag, "_irq_at_done"}, {31'b0, interrupt}, {31'b0, ie});
        end
        read_result(r, ovf, tag);
        bus_read(A_DONE, 8'h01, {tag, "_done"});
    endtask

    initial begin
        logic [31:0] r;
        bit          ovf;
        bit          seen;

        #2;
        chk("reset_dataOut", {24'h0, dataOut}, 32'd0);
        chk("reset_ready", {31'b0, memDataReady}, 32'd0);
        chk("reset_irq", {31'b0, interrupt}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        bus_read(A_STATUS, 8'h00, "reset_status");
        bus_read(A_DONE, 8'h00, "reset_done");

        run_fact(10, 1'b1);
        bus_read(4'd0, 8'h00, "n10_const_b0");
        bus_read(4'd1, 8'h5F, "n10_const_b1");
        bus_read(4'd2, 8'h37, "n10_const_b2");
        run_fact(13, 1'b1);
        bus_read(4'd3, 8'h73, "n13_const_b3");
        run_fact(12, 1'b1);
        bus_read(4'd3, 8'h1C, "n12_const_b3");
        run_fact(0, 1'b0);
        chk("ie0_irq_low", {31'b0, interrupt}, 32'd0);
        run_fact(1, 1'b1);

        // Unmapped reads, int_en readback, write wins over read.
        bus_read(A_START, 8'h00, "read_start_off");
        bus_read(4'd15, 8'h00, "read_unmapped");
        bus_read(A_INTEN, 8'h01, "read_int_en");
        cs = 1'b1; readmem = 1'b1; writemem = 1'b1; address = A_INTEN; dataIn = 8'h00;
        @(posedge clk);
        @(negedge clk);
        cs = 1'b0; readmem = 1'b0; writemem = 1'b0;
        chk("rw_collision_no_ready", {31'b0, memDataReady}, 32'd0);
        bus_read(A_INTEN, 8'h00, "rw_collision_wrote");
        bus_write(A_INTEN, 8'h01);

        // Operand and start writes are ignored while busy.
        bus_write('0, 8'd10);
        bus_write(A_START, 8'h00);
        bus_write('0, 8'd5);
        bus_write(A_START, 8'h00);
        bus_read(A_STATUS, 8'h01, "busy_status");
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (interrupt) seen = 1;
        end
        chk("busy_done_seen", {31'b0, seen}, 32'd1);
        model(10, r, ovf);
        read_result(r, ovf, "busy_ignored");

        // Done-clear on the completion edge: set wins.
        bus_write('0, 8'd3);
        bus_write(A_START, 8'h00);
        @(negedge clk);
        @(negedge clk);
        bus_write(A_DONE, 8'h00);
        chk("coincident_clear_irq", {31'b0, interrupt}, 32'd1);
        bus_read(A_DONE, 8'h01, "coincident_clear_done");
        bus_write(A_DONE, 8'hFF);
        chk("later_clear_irq", {31'b0, interrupt}, 32'd0);
        bus_read(A_DONE, 8'h00, "later_clear_done");

        // Reset in the middle of a long computation.
        bus_write('0, 8'd200);
        bus_write(A_START, 8'h00);
        bus_read(A_STATUS, 8'h01, "pre_reset_status");
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midreset_dataOut", {24'h0, dataOut}, 32'd0);
        chk("midreset_ready", {31'b0, memDataReady}, 32'd0);
        chk("midreset_irq", {31'b0, interrupt}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus_write(A_INTEN, 8'h01);
        repeat (220) @(negedge clk);
        chk("post_reset_no_irq", {31'b0, interrupt}, 32'd0);
        bus_read(A_DONE, 8'h00, "post_reset_done");
        bus_read(A_STATUS, 8'h00, "post_reset_status");
        run_fact(4, 1'b1);

        // Randomised operands against the reference model.
        for (int t = 0; t < 12; t++) begin
            run_fact(int'($urandom_range(0, 34)), 1'($urandom_range(0, 1)));
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
